bsk_prm_master: RTL and testbench
=================================

# bsk_prm_master

Bus master that sequences the BSK command-output (PRM) boards over the shared 16-bit parallel bus. On each request or refresh tick it writes the 32 command bits, the 32 indication bits and the terminal-enable control code to both PRM units (commands 16_01 and 32_17). It uses the nibble/complement integrity encoding, then reads back each unit's command and status registers and flags mismatches. It sits between the protocol core and the board bus, replacing software-driven bus cycles.

## Interface
- STROBE_LEN, 4: clocks `oRd`/`oWr` held low per transaction (≥1).
- SETUP_LEN, 2: clocks address/CS/data are stable before the strobe (≥1).
- REFRESH_PERIOD, 1000: idle clocks before an automatic cycle (≥2).

Ports:
- iClk  in  1  system clock.
- iRes  in  1  reset; **one clock; reset is synchronous and active-high.**
- iStart  in  1  one-clock request for a full update cycle.
- iCom  in  32  commands, active 1; bit n is command n+1.
- iInd  in  32  indication bits, active 1.
- iEnable  in  1  request terminal enable; 1 sends control 0xE1, 0 sends 0x00.
- iD  in  16  bus read data, already resolved from the tristate at top level.
- oD  out  16  bus write data.
- oDOe  out  1  bus drive enable, active 1.
- oRd  out  1  read strobe, active 0.
- oWr  out  1  write strobe, active 0.
- oA  out  2  register address.
- oCS  out  4  chip select: 4'b0111 for unit 0, 4'b0101 for unit 1, 4'b1111 when idle.
- oBusy  out  1  cycle in progress.
- oDone  out  1  one-clock pulse at the end of a cycle.
- oErr  out  2  per-unit verify error, sticky until the next cycle starts.

## Operation
- **Reset values:** oD=0, oDOe=0, oRd=1, oWr=1, oA=00, oCS=1111, oBusy=0, oDone=0, oErr=00. The pending flag and refresh counter are cleared.
- **Reset mid-cycle:** the block aborts on the same edge and returns to IDLE. The strobe rises and no further transactions are issued.
- **States:** IDLE → SETUP → STROBE → HOLD → (next transaction: SETUP | last: DONE) → IDLE.
- **Cycle start:** a cycle starts in IDLE when iStart=1 or the refresh counter reaches REFRESH_PERIOD-1.
  - iCom, iInd and iEnable are snapshotted at start.
  - oErr is cleared at start.
  - The refresh counter counts only in IDLE and clears at every start.
- **iStart while busy** sets a pending flag. The next cycle then starts on the clock after DONE. Multiple requests collapse into one.
- **Transaction order:** unit 0 first, then unit 1. For unit u, with c = command bits [16u+15:16u]:
  1. Write A=00, data {~c[7:4], c[7:4], ~c[3:0], c[3:0]}.
  2. Write A=01, data {~c[15:12], c[15:12], ~c[11:8], c[11:8]}.
  3. Write A=10, data iInd[16u+15:16u].
  4. Write A=11, data {8'h00, iEnable ? 8'hE1 : 8'h00}.
  5. Read A=01. Expect ~c.
  6. Read A=11. Expect high byte = 8'hA6+u and bit0 = iEnable snapshot. Other bits are ignored.
- **Verify errors:** any readback mismatch sets oErr[u]. The cycle still completes all transactions.
- **Bus drive:** oDOe=1 only during write transactions (SETUP, STROBE, HOLD); it is 0 for reads and in IDLE.

## Timing
- **SETUP phase:** SETUP_LEN clocks. oCS, oA and oD are valid; strobes are high.
- **STROBE phase:** STROBE_LEN clocks with the strobe low.
- **Read sampling:** iD is registered on the last STROBE clock edge.
- **HOLD phase:** 1 clock with the strobe high and CS/A/D unchanged. The board latches writes on the rising edge of iWr.
- **Transaction length:** T = SETUP_LEN + STROBE_LEN + 1 clocks.
- **oBusy** rises the clock after start and falls with oDone.
- **oDone** pulses 12·T + 1 clocks after the start edge; with defaults that is 85.
- **oCS** returns to 1111 on DONE.
- **Back-to-back cycles:** a pending cycle re-enters SETUP the clock after DONE, with one IDLE clock.

## Configuration
- **BSK_PRM_MASTER_VERIFY_EN defined:**
  - Both read transactions per unit are performed: 12 transactions.
  - oErr is active.
- **BSK_PRM_MASTER_VERIFY_EN undefined:**
  - Read transactions are omitted: 8 transactions.
  - oDone pulses 8·T + 1 clocks after start (57 with defaults).
  - oErr is constant 00.
  - oRd is constant 1.

## Test plan
- **Write encoding:** reset, then iStart with iCom=32'h0000_0001, iEnable=1 and an ideal board model. Required: first write is oCS=0111, oA=00, oD=16'hF0E1. Control write oD=16'h00E1. oDone at clock 85. oErr=00.
- **Command readback corruption:** board model flips bit 3 of unit 1 A=01 readback. Required: oErr=10 after oDone; the cycle length is unchanged.
- **Unit-code mismatch:** unit 0 returns high byte 8'hA7 at A=11. Required: oErr=01.
- **Refresh and pending requests:** iStart pulses twice during a busy cycle. Required: exactly one extra cycle starts the clock after DONE. With no iStart, a cycle auto-starts after 1000 idle clocks.
- **Reset mid-strobe:** iRes=1 during a write STROBE. Required: next clock oWr=1, oCS=1111, oDOe=0, oBusy=0, and no oDone pulse.
- **Verify compiled out:** build without BSK_PRM_MASTER_VERIFY_EN. Required: 8 transactions, oDone at clock 57, and oRd stays 1 throughout.

Source files
------------

// File: rtl/bsk_prm_master.sv
// PRM board bus master: writes nibble/complement-encoded commands, indications and enable
// code to both PRM units. Readback verification is built only with BSK_PRM_MASTER_VERIFY_EN.
module bsk_prm_master #(
  parameter int unsigned STROBE_LEN     = 4,
  parameter int unsigned SETUP_LEN      = 2,
  parameter int unsigned REFRESH_PERIOD = 1000
) (
  input  logic        iClk,
  input  logic        iRes,
  input  logic        iStart,
  input  logic [31:0] iCom,
  input  logic [31:0] iInd,
  input  logic        iEnable,
  input  logic [15:0] iD,
  output logic [15:0] oD,
  output logic        oDOe,
  output logic        oRd,
  output logic        oWr,
  output logic [1:0]  oA,
  output logic [3:0]  oCS,
  output logic        oBusy,
  output logic        oDone,
  output logic [1:0]  oErr
);

  localparam int unsigned MaxPh = (STROBE_LEN > SETUP_LEN) ? STROBE_LEN : SETUP_LEN;
  localparam int unsigned PhW   = $clog2(MaxPh + 1);
  localparam int unsigned RefW  = $clog2(REFRESH_PERIOD);

  localparam logic [PhW-1:0]  SetupLast  = PhW'(SETUP_LEN - 1);
  localparam logic [PhW-1:0]  StrobeLast = PhW'(STROBE_LEN - 1);
  localparam logic [RefW-1:0] RefLast    = RefW'(REFRESH_PERIOD - 1);

`ifdef BSK_PRM_MASTER_VERIFY_EN
  localparam logic [2:0] LastStep = 3'd5;
`else
  localparam logic [2:0] LastStep = 3'd3;
`endif

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

  state_e          state_q, state_d;
  logic [PhW-1:0]  cnt_q, cnt_d;
  logic [RefW-1:0] ref_q, ref_d;
  logic [2:0]      step_q, step_d;
  logic            unit_q, unit_d;
  logic            pend_q, pend_d;
  logic [31:0]     com_q, com_d;
  logic [31:0]     ind_q, ind_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      err_q, err_d;

  logic [15:0]     d_q, d_d;
  logic            doe_q, doe_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [1:0]      a_q, a_d;
  logic [3:0]      cs_q, cs_d;

  logic [15:0]     cmd_n;
  logic [15:0]     ind_n;
  logic            start;

  function automatic logic [15:0] enc_byte(input logic [7:0] b);
    return {~b[7:4], b[7:4], ~b[3:0], b[3:0]};
  endfunction

`ifdef BSK_PRM_MASTER_VERIFY_EN
  logic [15:0] cmd_q;
  assign cmd_q = unit_q ? com_q[31:16] : com_q[15:0];
`else
  logic unused_id;
  assign unused_id = ^iD;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    step_d  = step_q;
    unit_d  = unit_q;
    pend_d  = pend_q;
    com_d   = com_q;
    ind_d   = ind_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    start   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (iStart || pend_q || (ref_q == RefLast)) begin
          start = 1'b1;
        end else begin
          ref_d = ref_q + 1'b1;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStrobe: begin
        if (cnt_q == StrobeLast) begin
          state_d = StHold;
          cnt_d   = '0;
`ifdef BSK_PRM_MASTER_VERIFY_EN
          // Readback is judged on the edge that ends the read strobe.
          if ((step_q == 3'd4) && (iD != ~cmd_q)) begin
            err_d[unit_q] = 1'b1;
          end
          if ((step_q == 3'd5) &&
              ((iD[15:8] != (8'hA6 + {7'd0, unit_q})) || (iD[0] != en_q))) begin
            err_d[unit_q] = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if ((step_q == LastStep) && unit_q) begin
          state_d = StDone;
        end else begin
          state_d = StSetup;
          if (step_q == LastStep) begin
            step_d = 3'd0;
            unit_d = 1'b1;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (iStart && (state_q != StIdle)) begin
      pend_d = 1'b1;
    end

    if (start) begin
      state_d = StSetup;
      cnt_d   = '0;
      ref_d   = '0;
      step_d  = 3'd0;
      unit_d  = 1'b0;
      pend_d  = 1'b0;
      com_d   = iCom;
      ind_d   = iInd;
      en_d    = iEnable;
      busy_d  = 1'b1;
      err_d   = 2'b00;
    end
  end

  // Bus outputs are registered from the next state so they never glitch.
  always_comb begin
    cmd_n = unit_d ? com_d[31:16] : com_d[15:0];
    ind_n = unit_d ? ind_d[31:16] : ind_d[15:0];
    d_d   = '0;
    doe_d = 1'b0;
    rd_d  = 1'b1;
    wr_d  = 1'b1;
    a_d   = 2'b00;
    cs_d  = 4'b1111;
    if ((state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold)) begin
      cs_d = unit_d ? 4'b0101 : 4'b0111;
      case (step_d)
        3'd0: begin
          a_d = 2'b00;
          d_d = enc_byte(cmd_n[7:0]);
        end
        3'd1: begin
          a_d = 2'b01;
          d_d = enc_byte(cmd_n[15:8]);
        end
        3'd2: begin
          a_d = 2'b10;
          d_d = ind_n;
        end
        3'd3: begin
          a_d = 2'b11;
          d_d = {8'h00, en_d ? 8'hE1 : 8'h00};
        end
        3'd4:    a_d = 2'b01;
        default: a_d = 2'b11;
      endcase
      doe_d = (step_d < 3'd4);
      if (state_d == StStrobe) begin
        if (doe_d) begin
          wr_d = 1'b0;
        end else begin
          rd_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRes) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ref_q   <= '0;
      step_q  <= 3'd0;
      unit_q  <= 1'b0;
      pend_q  <= 1'b0;
      com_q   <= '0;
      ind_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 2'b00;
      d_q     <= '0;
      doe_q   <= 1'b0;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      a_q     <= 2'b00;
      cs_q    <= 4'b1111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      step_q  <= step_d;
      unit_q  <= unit_d;
      pend_q  <= pend_d;
      com_q   <= com_d;
      ind_q   <= ind_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      d_q     <= d_d;
      doe_q   <= doe_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      a_q     <= a_d;
      cs_q    <= cs_d;
    end
  end

  assign oD    = d_q;
  assign oDOe  = doe_q;
  assign oRd   = rd_q;
  assign oWr   = wr_q;
  assign oA    = a_q;
  assign oCS   = cs_q;
  assign oBusy = busy_q;
  assign oDone = done_q;
`ifdef BSK_PRM_MASTER_VERIFY_EN
  assign oErr  = err_q;
`else
  assign oErr  = 2'b00;
`endif

endmodule

// File: tb/tb_bsk_prm_master.sv
// Directed self-checking bench for bsk_prm_master with a combinational PRM board model.
module tb_bsk_prm_master;

`ifdef BSK_PRM_MASTER_VERIFY_EN
  localparam int NWr = 8;
  localparam int NRd = 4;
  localparam int DoneAt = 85;
`else
  localparam int NWr = 8;
  localparam int NRd = 0;
  localparam int DoneAt = 57;
`endif

  logic        iClk, iRes, iStart, iEnable;
  logic [31:0] iCom, iInd;
  logic [15:0] iD, oD;
  logic        oDOe, oRd, oWr, oBusy, oDone;
  logic [1:0]  oA, oErr;
  logic [3:0]  oCS;

  int total = 0;
  int bad = 0;

  // Board model state, independent of what the DUT snapshotted.
  logic [31:0] mdl_com = '0;
  logic        mdl_en = 1'b0;
  logic        flip_cmd = 1'b0;
  logic        bad_code = 1'b0;
  logic        bu;
  logic [15:0] bcmd;

  int          nwr, nrd;
  logic        rd_low = 1'b0;
  logic [15:0] wd [2][4];

  bsk_prm_master dut (
    .iClk   (iClk),
    .iRes   (iRes),
    .iStart (iStart),
    .iCom   (iCom),
    .iInd   (iInd),
    .iEnable(iEnable),
    .iD     (iD),
    .oD     (oD),
    .oDOe   (oDOe),
    .oRd    (oRd),
    .oWr    (oWr),
    .oA     (oA),
    .oCS    (oCS),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oErr   (oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  assign bu   = (oCS == 4'b0101);
  assign bcmd = bu ? mdl_com[31:16] : mdl_com[15:0];

  always_comb begin
    iD = 16'h0000;
    if (!oRd) begin
      if (oA == 2'b01) begin
        iD = ~bcmd;
        if (bu && flip_cmd) iD[3] = ~iD[3];
      end else if (oA == 2'b11) begin
        iD = {(bu || bad_code) ? 8'hA7 : 8'hA6, 7'h2A, mdl_en};
      end
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call right after the start edge; returns clocks from start edge to oDone (0 = timeout).
  task automatic run_cycle(output int done_at);
    logic pw, pr;
    done_at = 0;
    nwr = 0;
    nrd = 0;
    pw = oWr;
    pr = oRd;
    for (int k = 1; k <= 300 && done_at == 0; k++) begin
      tick();
      if (pw && !oWr) nwr++;
      if (pr && !oRd) nrd++;
      if (!oRd) rd_low = 1'b1;
      if (!oWr) wd[bu ? 1 : 0][oA] = oD;
      pw = oWr;
      pr = oRd;
      if (oDone) done_at = k;
    end
  endtask

  task automatic start_cycle(input logic [31:0] com, input logic [31:0] ind, input logic en);
    iCom = com;
    iInd = ind;
    iEnable = en;
    mdl_com = com;
    mdl_en = en;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  int d;
  int first;
  int cnt;
  logic found;

  initial begin
    iRes = 1'b1;
    iStart = 1'b0;
    iCom = '0;
    iInd = '0;
    iEnable = 1'b0;
    tick();
    iRes = 1'b0;
    check("rst_oD", oD, 16'h0000);
    check("rst_oDOe", oDOe, 1'b0);
    check("rst_oRd", oRd, 1'b1);
    check("rst_oWr", oWr, 1'b1);
    check("rst_oA", oA, 2'b00);
    check("rst_oCS", oCS, 4'b1111);
    check("rst_oBusy", oBusy, 1'b0);
    check("rst_oDone", oDone, 1'b0);
    check("rst_oErr", oErr, 2'b00);

    // Write encoding, ideal board
    start_cycle(32'h0000_0001, 32'h1234_5678, 1'b1);
    check("a_busy", oBusy, 1'b1);
    check("a_cs0", oCS, 4'b0111);
    check("a_a0", oA, 2'b00);
    check("a_d0", oD, 16'hF0E1);
    check("a_doe0", oDOe, 1'b1);
    check("a_wr0", oWr, 1'b1);
    run_cycle(d);
    check("a_done_at", d, DoneAt);
    check("a_nwr", nwr, NWr);
    check("a_nrd", nrd, NRd);
    check("a_u0_a0", wd[0][0], 16'hF0E1);
    check("a_u0_a1", wd[0][1], 16'hF0F0);
    check("a_u0_a2", wd[0][2], 16'h5678);
    check("a_u0_a3", wd[0][3], 16'h00E1);
    check("a_u1_a0", wd[1][0], 16'hF0F0);
    check("a_u1_a2", wd[1][2], 16'h1234);
    check("a_u1_a3", wd[1][3], 16'h00E1);
    check("a_err", oErr, 2'b00);
    check("a_busy_end", oBusy, 1'b0);
    check("a_cs_end", oCS, 4'b1111);
    check("a_doe_end", oDOe, 1'b0);
    tick();
    check("a_done_pulse", oDone, 1'b0);

    // Second pattern; inputs change after start to prove snapshotting
    start_cycle(32'hA5C3_0F96, 32'hDEAD_BEEF, 1'b0);
    iCom = 32'hFFFF_FFFF;
    iInd = 32'h0000_0000;
    iEnable = 1'b1;
    run_cycle(d);
    check("b_done_at", d, DoneAt);
    check("b_u0_a0", wd[0][0], 16'h6996);
    check("b_u0_a1", wd[0][1], 16'hF00F);
    check("b_u0_a2", wd[0][2], 16'hBEEF);
    check("b_u0_a3", wd[0][3], 16'h0000);
    check("b_u1_a0", wd[1][0], 16'h3CC3);
    check("b_u1_a1", wd[1][1], 16'h5AA5);
    check("b_u1_a2", wd[1][2], 16'hDEAD);
    check("b_u1_a3", wd[1][3], 16'h0000);
    check("b_err", oErr, 2'b00);
    tick();

`ifdef BSK_PRM_MASTER_VERIFY_EN
    flip_cmd = 1'b1;
    start_cycle(32'h1357_9BDF, 32'h0, 1'b1);
    run_cycle(d);
    check("c_done_at", d, DoneAt);
    check("c_err", oErr, 2'b10);
    flip_cmd = 1'b0;
    tick();
    bad_code = 1'b1;
    start_cycle(32'h1357_9BDF, 32'h0, 1'b0);
    run_cycle(d);
    check("u_done_at", d, DoneAt);
    check("u_err", oErr, 2'b01);
    bad_code = 1'b0;
    tick();
    start_cycle(32'h1357_9BDF, 32'h0, 1'b1);
    check("clr_err", oErr, 2'b00);
    run_cycle(d);
    check("ok_err", oErr, 2'b00);
    tick();
`endif

    // Two requests while busy collapse into one follow-up cycle
    start_cycle(32'h0000_00FF, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    run_cycle(d);
    check("p_done_at", d + 17, DoneAt);
    check("p_busy_at_done", oBusy, 1'b0);
    tick();
    check("p_restart_busy", oBusy, 1'b1);
    check("p_restart_cs", oCS, 4'b0111);
    run_cycle(d);
    check("p2_done_at", d, DoneAt);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (oBusy) cnt++;
    end
    check("p_no_third", cnt, 0);

    // Automatic refresh after idle clocks
    iRes = 1'b1;
    tick();
    iRes = 1'b0;
    first = 0;
    for (int k = 1; k <= 1100 && first == 0; k++) begin
      tick();
      if (oBusy) first = k;
    end
    check("r_start_at", first, 1000);
    run_cycle(d);
    check("r_done_at", d, DoneAt);
    tick();

    // Reset in the middle of a write strobe
    start_cycle(32'h8000_0001, 32'h0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (!oWr) found = 1'b1;
    end
    check("m_strobe_seen", found, 1'b1);
    tick();
    iRes = 1'b1;
    tick();
    iRes = 1'b0;
    check("m_wr", oWr, 1'b1);
    check("m_cs", oCS, 4'b1111);
    check("m_doe", oDOe, 1'b0);
    check("m_busy", oBusy, 1'b0);
    check("m_done", oDone, 1'b0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (oDone || oBusy || !oWr) cnt++;
    end
    check("m_quiet", cnt, 0);

`ifndef BSK_PRM_MASTER_VERIFY_EN
    check("rd_never_low", rd_low, 1'b0);
    check("err_const", oErr, 2'b00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
